soc_clk_rst_seq_csr: RTL and testbench



---
 rtl/soc_clk_rst_seq_csr.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_soc_clk_rst_seq_csr.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_clk_rst_seq_csr.sv
// SoC clock/reset control CSR bank: boot address, hart ID, clock enable, soft resets,
// temperature, PLL status, and a shared sequencer that retunes one PLL divider at a time.
module soc_clk_rst_seq_csr #(
    parameter int unsigned NUM_CORE          = 4,
    parameter int unsigned XLEN              = 64,
    parameter int unsigned FB_DIV_WIDTH      = 12,
    parameter logic [FB_DIV_WIDTH-1:0] FB_DIV_RST = 12'd40,
    parameter int unsigned TEMP_SENSOR_WIDTH = 10,
    parameter int unsigned GATE_CYCLES       = 4,
    parameter int unsigned SETTLE_CYCLES     = 8,
    parameter int unsigned LOCK_TIMEOUT      = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  arst_ni,
    input  logic                                  mem_we_i,
    input  logic [11:0]                           mem_waddr_i,
    input  logic [63:0]                           mem_wdata_i,
    input  logic [7:0]                            mem_wstrb_i,
    output logic [1:0]                            mem_wresp_o,
    input  logic                                  mem_re_i,
    input  logic [11:0]                           mem_raddr_i,
    output logic [63:0]                           mem_rdata_o,
    output logic [1:0]                            mem_rresp_o,
    output logic [NUM_CORE*XLEN-1:0]              boot_addr_vec_o,
    output logic [NUM_CORE*XLEN-1:0]              hart_id_vec_o,
    output logic [NUM_CORE-1:0]                   core_clk_en_vec_o,
    output logic [NUM_CORE-1:0]                   core_arst_vec_o,
    output logic [NUM_CORE*FB_DIV_WIDTH-1:0]      core_pll_fb_div_vec_o,
    input  logic [NUM_CORE-1:0]                   core_pll_locked_i,
    input  logic [NUM_CORE*FB_DIV_WIDTH-1:0]      core_pll_fb_div_vec_i,
    input  logic [NUM_CORE*TEMP_SENSOR_WIDTH-1:0] core_temp_sensor_vec_i,
    output logic                                  ram_clk_en_o,
    output logic                                  ram_arst_o,
    output logic [FB_DIV_WIDTH-1:0]               ram_pll_fb_div_o,
    input  logic                                  ram_pll_locked_i,
    input  logic [FB_DIV_WIDTH-1:0]               ram_pll_fb_div_i,
    output logic                                  glob_arst_o,
    output logic                                  seq_busy_o
);

    localparam int unsigned NB    = NUM_CORE + 1;
    localparam int unsigned CH_W  = $clog2(NB);
    localparam int unsigned IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + GATE_CYCLES + 1);
    localparam logic [CH_W-1:0] RAM_CH = CH_W'(NUM_CORE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GATE   = 3'd1;
    localparam logic [2:0] S_PROG   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UNGATE = 3'd4;

    function automatic logic [63:0] f_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [63:0] f_merge(input logic [63:0] cur, input logic [63:0] wd,
                                            input logic [7:0] strb);
        return (cur & ~f_mask(strb)) | (wd & f_mask(strb));
    endfunction

    logic [XLEN-1:0]              r_boot_addr [NUM_CORE];
    logic [XLEN-1:0]              r_hart_id   [NUM_CORE];
    logic [FB_DIV_WIDTH-1:0]      r_fb_tgt    [NB];
    logic [FB_DIV_WIDTH-1:0]      r_fb_out    [NB];
    logic [FB_DIV_WIDTH-1:0]      w_fb_act    [NB];
    logic [TEMP_SENSOR_WIDTH-1:0] w_temp      [NUM_CORE];
    logic [NB-1:0]                r_clk_en_sw, r_arst, r_gate_mask, r_timeout;
    logic                         r_glob_arst, r_busy;
    logic [2:0]                   r_state, w_state_nxt;
    logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]              r_chan, w_chan_nxt, w_tgt_chan;
    logic [NB-1:0]                w_lock_all, w_chan_oh, w_gate_set, w_gate_clr, w_tmo_set, w_tmo_clr;
    logic                         w_prog;
    logic [5:0]                   w_widx, w_ridx;
    logic                         w_widx_ok, w_ridx_ok;
    logic [IDX_W-1:0]             w_widx_c, w_ridx_c;
    logic w_sel_boot, w_sel_hart, w_sel_tgt, w_sel_clken, w_sel_arst, w_sel_glob, w_sel_tmo;
    logic w_wr_ok, w_we, w_rd_ok;
    logic [63:0] w_rdata;
    logic w_unused;

    assign w_unused   = ^{mem_re_i, mem_waddr_i[2:0], mem_raddr_i[2:0]};
    assign w_widx     = mem_waddr_i[8:3];
    assign w_ridx     = mem_raddr_i[8:3];
    assign w_widx_ok  = (w_widx < 6'(NUM_CORE));
    assign w_ridx_ok  = (w_ridx < 6'(NUM_CORE));
    assign w_widx_c   = IDX_W'(w_widx);
    assign w_ridx_c   = IDX_W'(w_ridx);
    assign w_lock_all = {ram_pll_locked_i, core_pll_locked_i};
    assign w_chan_oh  = NB'(1'b1) << r_chan;
    assign w_fb_act[NUM_CORE] = ram_pll_fb_div_i;

    for (genvar g = 0; g < NUM_CORE; g++) begin : g_core
        assign boot_addr_vec_o[g*XLEN +: XLEN]                = r_boot_addr[g];
        assign hart_id_vec_o[g*XLEN +: XLEN]                  = r_hart_id[g];
        assign core_pll_fb_div_vec_o[g*FB_DIV_WIDTH +: FB_DIV_WIDTH] = r_fb_out[g];
        assign w_fb_act[g] = core_pll_fb_div_vec_i[g*FB_DIV_WIDTH +: FB_DIV_WIDTH];
        assign w_temp[g]   = core_temp_sensor_vec_i[g*TEMP_SENSOR_WIDTH +: TEMP_SENSOR_WIDTH];
    end

    // Gated channels stay off regardless of the software enable.
    assign core_clk_en_vec_o = r_clk_en_sw[NUM_CORE-1:0] & ~r_gate_mask[NUM_CORE-1:0];
    assign ram_clk_en_o      = r_clk_en_sw[NUM_CORE] & ~r_gate_mask[NUM_CORE];
    assign core_arst_vec_o   = r_arst[NUM_CORE-1:0];
    assign ram_arst_o        = r_arst[NUM_CORE];
    assign ram_pll_fb_div_o  = r_fb_out[NUM_CORE];
    assign glob_arst_o       = r_glob_arst;
    assign seq_busy_o        = r_busy;

    // Write address decode into per-register selects.
    always_comb begin
        w_sel_boot  = 1'b0;
        w_sel_hart  = 1'b0;
        w_sel_tgt   = 1'b0;
        w_sel_clken = 1'b0;
        w_sel_arst  = 1'b0;
        w_sel_glob  = 1'b0;
        w_sel_tmo   = 1'b0;
        w_tgt_chan  = RAM_CH;
        case (mem_waddr_i[11:9])
            3'd0: w_sel_boot = w_widx_ok;
            3'd1: w_sel_hart = w_widx_ok;
            3'd2: begin
                w_sel_tgt  = w_widx_ok;
                w_tgt_chan = CH_W'(w_widx);
            end
            3'd4: w_sel_tgt = (w_widx == 6'd0);
            3'd7: begin
                case (w_widx)
                    6'd1:    w_sel_clken = 1'b1;
                    6'd2:    w_sel_arst  = 1'b1;
                    6'd3:    w_sel_glob  = 1'b1;
                    6'd5:    w_sel_tmo   = 1'b1;
                    default: w_sel_clken = 1'b0;
                endcase
            end
            default: w_sel_boot = 1'b0;
        endcase
    end

    assign w_wr_ok = w_sel_boot | w_sel_hart | (w_sel_tgt & ~r_busy) | w_sel_clken |
                     w_sel_arst | w_sel_glob | w_sel_tmo;
    assign w_we        = mem_we_i & w_wr_ok;
    assign mem_wresp_o = w_wr_ok ? 2'b00 : 2'b10;

    // RW1C timeout clear; the channel being sequenced is protected while busy.
    always_comb begin
        w_tmo_clr = {NB{1'b0}};
        if (w_we && w_sel_tmo) begin
            w_tmo_clr = NB'(mem_wdata_i & f_mask(mem_wstrb_i));
            if (r_busy) begin
                w_tmo_clr = w_tmo_clr & ~w_chan_oh;
            end else begin
                w_tmo_clr = w_tmo_clr;
            end
        end else begin
            w_tmo_clr = {NB{1'b0}};
        end
    end

    // Sequencer next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_gate_set  = {NB{1'b0}};
        w_gate_clr  = {NB{1'b0}};
        w_tmo_set   = {NB{1'b0}};
        w_prog      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_we && w_sel_tgt) begin
                    w_state_nxt = S_GATE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_chan_nxt  = w_tgt_chan;
                    w_gate_set  = NB'(1'b1) << w_tgt_chan;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GATE: begin
                if (r_cnt == CNT_W'(GATE_CYCLES - 1)) begin
                    w_state_nxt = S_PROG;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PROG: begin
                w_prog      = 1'b1;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Lock wins over timeout on the final count.
                if (w_lock_all[r_chan] && (r_cnt >= CNT_W'(SETTLE_CYCLES))) begin
                    w_state_nxt = S_UNGATE;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_tmo_set   = w_chan_oh;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_UNGATE: begin
                w_gate_clr  = w_chan_oh;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gate_clr  = w_chan_oh;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, gate mask and timeout flags.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_chan      <= {CH_W{1'b0}};
            r_busy      <= 1'b0;
            r_gate_mask <= {NB{1'b0}};
            r_timeout   <= {NB{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_chan      <= w_chan_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_gate_mask <= (r_gate_mask | w_gate_set) & ~w_gate_clr & ~w_tmo_clr;
            r_timeout   <= (r_timeout | w_tmo_set) & ~w_tmo_clr;
        end
    end

    // Software-visible CSR storage and divider programming.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_CORE; i++) begin
                r_boot_addr[i] <= {XLEN{1'b0}};
                r_hart_id[i]   <= {XLEN{1'b0}};
            end
            for (int i = 0; i < NB; i++) begin
                r_fb_tgt[i] <= FB_DIV_RST;
                r_fb_out[i] <= FB_DIV_RST;
            end
            r_clk_en_sw <= {NB{1'b0}};
            r_arst      <= {NB{1'b0}};
            r_glob_arst <= 1'b0;
        end else begin
            if (w_we && w_sel_boot)
                r_boot_addr[w_widx_c] <= XLEN'(f_merge(64'(r_boot_addr[w_widx_c]), mem_wdata_i, mem_wstrb_i));
            if (w_we && w_sel_hart)
                r_hart_id[w_widx_c] <= XLEN'(f_merge(64'(r_hart_id[w_widx_c]), mem_wdata_i, mem_wstrb_i));
            if (w_we && w_sel_tgt)
                r_fb_tgt[w_tgt_chan] <= FB_DIV_WIDTH'(f_merge(64'(r_fb_tgt[w_tgt_chan]), mem_wdata_i, mem_wstrb_i));
            if (w_prog)
                r_fb_out[r_chan] <= r_fb_tgt[r_chan];
            if (w_we && w_sel_clken)
                r_clk_en_sw <= NB'(f_merge(64'(r_clk_en_sw), mem_wdata_i, mem_wstrb_i));
            if (w_we && w_sel_arst)
                r_arst <= NB'(f_merge(64'(r_arst), mem_wdata_i, mem_wstrb_i));
            if (w_we && w_sel_glob)
                r_glob_arst <= (mem_wdata_i[0] & mem_wstrb_i[0]) | (r_glob_arst & ~mem_wstrb_i[0]);
        end
    end

    // Combinational read decode.
    always_comb begin
        w_rdata = 64'd0;
        w_rd_ok = 1'b0;
        case (mem_raddr_i[11:9])
            3'd0: begin w_rd_ok = w_ridx_ok; w_rdata = w_ridx_ok ? 64'(r_boot_addr[w_ridx_c]) : 64'd0; end
            3'd1: begin w_rd_ok = w_ridx_ok; w_rdata = w_ridx_ok ? 64'(r_hart_id[w_ridx_c]) : 64'd0; end
            3'd2: begin w_rd_ok = w_ridx_ok; w_rdata = w_ridx_ok ? 64'(r_fb_tgt[CH_W'(w_ridx)]) : 64'd0; end
            3'd3: begin w_rd_ok = w_ridx_ok; w_rdata = w_ridx_ok ? 64'(w_fb_act[CH_W'(w_ridx)]) : 64'd0; end
            3'd6: begin w_rd_ok = w_ridx_ok; w_rdata = w_ridx_ok ? 64'(w_temp[w_ridx_c]) : 64'd0; end
            3'd4: begin
                if (w_ridx == 6'd0) begin
                    w_rd_ok = 1'b1;
                    w_rdata = 64'(r_fb_tgt[RAM_CH]);
                end else if (w_ridx == 6'd32) begin
                    w_rd_ok = 1'b1;
                    w_rdata = 64'(w_fb_act[RAM_CH]);
                end else begin
                    w_rd_ok = 1'b0;
                    w_rdata = 64'd0;
                end
            end
            3'd7: begin
                w_rd_ok = 1'b1;
                case (w_ridx)
                    6'd0:    w_rdata = 64'(w_lock_all);
                    6'd1:    w_rdata = 64'(r_clk_en_sw);
                    6'd2:    w_rdata = 64'(r_arst);
                    6'd3:    w_rdata = 64'(r_glob_arst);
                    6'd4:    w_rdata = {r_busy, 57'd0, 6'(r_chan)};
                    6'd5:    w_rdata = 64'(r_timeout);
                    default: begin w_rd_ok = 1'b0; w_rdata = 64'd0; end
                endcase
            end
            default: begin w_rd_ok = 1'b0; w_rdata = 64'd0; end
        endcase
    end

    assign mem_rdata_o = w_rdata;
    assign mem_rresp_o = w_rd_ok ? 2'b00 : 2'b10;

endmodule

// File: tb/tb_soc_clk_rst_seq_csr.sv
// Self-checking bench for soc_clk_rst_seq_csr: register access, retune sequencing,
// settle window, busy rejection, timeout recovery and reset mid-sequence.
module tb_soc_clk_rst_seq_csr;
    localparam int NC = 4;
    localparam int FW = 12;

    logic clk_i = 1'b0;
    logic arst_ni = 1'b0;
    logic mem_we_i = 1'b0, mem_re_i = 1'b0;
    logic [11:0] mem_waddr_i = 12'd0, mem_raddr_i = 12'd0;
    logic [63:0] mem_wdata_i = 64'd0, mem_rdata_o;
    logic [7:0]  mem_wstrb_i = 8'd0;
    logic [1:0]  mem_wresp_o, mem_rresp_o;
    logic [NC*64-1:0] boot_addr_vec_o, hart_id_vec_o;
    logic [NC-1:0] core_clk_en_vec_o, core_arst_vec_o;
    logic [NC*FW-1:0] core_pll_fb_div_vec_o;
    logic [NC-1:0] core_pll_locked_i = 4'd0;
    logic [NC*FW-1:0] core_pll_fb_div_vec_i = {12'd13, 12'd12, 12'd11, 12'd10};
    logic [NC*10-1:0] core_temp_sensor_vec_i = {10'd300, 10'd200, 10'd100, 10'd50};
    logic ram_clk_en_o, ram_arst_o, ram_pll_locked_i = 1'b0, glob_arst_o, seq_busy_o;
    logic [FW-1:0] ram_pll_fb_div_o, ram_pll_fb_div_i = 12'd99;

    typedef struct packed { logic [63:0] data; logic [1:0] resp; } exp_t;
    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass = 0;

    soc_clk_rst_seq_csr dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .mem_wstrb_i(mem_wstrb_i), .mem_wresp_o(mem_wresp_o),
        .mem_re_i(mem_re_i), .mem_raddr_i(mem_raddr_i), .mem_rdata_o(mem_rdata_o),
        .mem_rresp_o(mem_rresp_o),
        .boot_addr_vec_o(boot_addr_vec_o), .hart_id_vec_o(hart_id_vec_o),
        .core_clk_en_vec_o(core_clk_en_vec_o), .core_arst_vec_o(core_arst_vec_o),
        .core_pll_fb_div_vec_o(core_pll_fb_div_vec_o), .core_pll_locked_i(core_pll_locked_i),
        .core_pll_fb_div_vec_i(core_pll_fb_div_vec_i), .core_temp_sensor_vec_i(core_temp_sensor_vec_i),
        .ram_clk_en_o(ram_clk_en_o), .ram_arst_o(ram_arst_o), .ram_pll_fb_div_o(ram_pll_fb_div_o),
        .ram_pll_locked_i(ram_pll_locked_i), .ram_pll_fb_div_i(ram_pll_fb_div_i),
        .glob_arst_o(glob_arst_o), .seq_busy_o(seq_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Commits on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] s,
                             output logic [1:0] resp);
        @(negedge clk_i);
        mem_we_i = 1'b1; mem_waddr_i = a; mem_wdata_i = d; mem_wstrb_i = s;
        #1 resp = mem_wresp_o;
        @(posedge clk_i);
        #1 mem_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [63:0] d, output logic [1:0] r);
        @(negedge clk_i);
        mem_re_i = 1'b1; mem_raddr_i = a;
        #1 d = mem_rdata_o; r = mem_rresp_o;
        mem_re_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [3];
        logic [63:0] exp_d [3];
        logic [63:0] d; logic [1:0] r; exp_t e;
        addrs = '{12'h400, 12'h800, 12'hE08};
        exp_d = '{64'd40, 64'd40, 64'd0};
        arst_ni = 1'b0;
        tick(2);
        @(negedge clk_i) arst_ni = 1'b1;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", seq_busy_o); else n_pass++;
        n_checks++;
        if (core_pll_fb_div_vec_o !== {4{12'd40}} || ram_pll_fb_div_o !== 12'd40)
            $display("FAIL reset_div: got %h/%h want all 028", core_pll_fb_div_vec_o, ram_pll_fb_div_o);
        else n_pass++;
        n_checks++;
        if ({core_clk_en_vec_o, ram_clk_en_o, core_arst_vec_o, ram_arst_o, glob_arst_o} !== 11'd0 ||
            boot_addr_vec_o !== '0 || hart_id_vec_o !== '0)
            $display("FAIL reset_outputs: clk_en=%h arst=%h glob=%b want 0", core_clk_en_vec_o, core_arst_vec_o, glob_arst_o);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{exp_d[i], 2'b00});
            bus_read(addrs[i], d, r);
            e = sb_q.pop_front();
            n_checks++;
            if (d !== e.data || r !== e.resp)
                $display("FAIL reset_read %h: got %h/%b want %h/%b", addrs[i], d, r, e.data, e.resp);
            else n_pass++;
        end
    endtask

    task automatic test_ro_write();
        logic [63:0] d; logic [1:0] r; exp_t e;
        bus_write(12'hE00, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL ro_locked_wresp: got %b want 10", r); else n_pass++;
        bus_write(12'h608, 64'd7, 8'hFF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL ro_actual_wresp: got %b want 10", r); else n_pass++;
        sb_q.push_back('{64'd0, 2'b00});
        bus_read(12'hE00, d, r);
        e = sb_q.pop_front();
        n_checks++;
        if (d !== e.data || r !== e.resp) $display("FAIL ro_locked_read: got %h/%b want %h/%b", d, r, e.data, e.resp);
        else n_pass++;
    endtask

    task automatic test_readback();
        logic [63:0] d; logic [1:0] r; exp_t e;
        logic [11:0] addrs [7];
        exp_t exps [7];
        bus_write(12'h218, 64'hFFFF_0000_DEAD_BEEF, 8'hFF, r);
        bus_write(12'h000, 64'h1122_3344_5566_7788, 8'hFF, r);
        bus_write(12'h000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, r);
        n_checks++;
        if (boot_addr_vec_o[63:0] !== 64'h1122_3344_BBBB_BBBB)
            $display("FAIL strobe_boot_out: got %h want 11223344bbbbbbbb", boot_addr_vec_o[63:0]);
        else n_pass++;
        bus_write(12'h020, 64'd5, 8'hFF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL boot_idx4_wresp: got %b want 10", r); else n_pass++;
        addrs = '{12'h000, 12'h218, 12'h610, 12'h900, 12'hC18, 12'hA00, 12'h020};
        exps  = '{'{64'h1122_3344_BBBB_BBBB, 2'b00}, '{64'hFFFF_0000_DEAD_BEEF, 2'b00},
                  '{64'd12, 2'b00}, '{64'd99, 2'b00}, '{64'd300, 2'b00},
                  '{64'd0, 2'b10}, '{64'd0, 2'b10}};
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back(exps[i]);
            bus_read(addrs[i], d, r);
            e = sb_q.pop_front();
            n_checks++;
            if (d !== e.data || r !== e.resp)
                $display("FAIL readback %h: got %h/%b want %h/%b", addrs[i], d, r, e.data, e.resp);
            else n_pass++;
        end
    endtask

    task automatic test_retune_lock10();
        logic [1:0] r;
        bus_write(12'hE08, 64'h1F, 8'hFF, r);
        n_checks++;
        if (core_clk_en_vec_o !== 4'hF || ram_clk_en_o !== 1'b1)
            $display("FAIL retune_clk_en_init: got %h/%b want f/1", core_clk_en_vec_o, ram_clk_en_o);
        else n_pass++;
        bus_write(12'h410, 64'd64, 8'hFF, r);
        n_checks++;
        if (r !== 2'b00 || core_clk_en_vec_o !== 4'hB || seq_busy_o !== 1'b1)
            $display("FAIL retune_gate: resp=%b clk_en=%h busy=%b want 00/b/1", r, core_clk_en_vec_o, seq_busy_o);
        else n_pass++;
        tick(4);
        n_checks++;
        if (core_pll_fb_div_vec_o[2*FW +: FW] !== 12'd40)
            $display("FAIL retune_div_early: got %0d want 40", core_pll_fb_div_vec_o[2*FW +: FW]);
        else n_pass++;
        tick(1);
        n_checks++;
        if (core_pll_fb_div_vec_o[2*FW +: FW] !== 12'd64)
            $display("FAIL retune_div_prog: got %0d want 64", core_pll_fb_div_vec_o[2*FW +: FW]);
        else n_pass++;
        tick(10);
        n_checks++;
        if (seq_busy_o !== 1'b1 || core_clk_en_vec_o[2] !== 1'b0)
            $display("FAIL retune_wait: busy=%b en2=%b want 1/0", seq_busy_o, core_clk_en_vec_o[2]);
        else n_pass++;
        core_pll_locked_i[2] = 1'b1;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b1 || core_clk_en_vec_o[2] !== 1'b0)
            $display("FAIL retune_ungate_state: busy=%b en2=%b want 1/0", seq_busy_o, core_clk_en_vec_o[2]);
        else n_pass++;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b0 || core_clk_en_vec_o !== 4'hF)
            $display("FAIL retune_done: busy=%b clk_en=%h want 0/f", seq_busy_o, core_clk_en_vec_o);
        else n_pass++;
    endtask

    task automatic test_lock_settle();
        logic [1:0] r;
        core_pll_locked_i[1] = 1'b1;
        bus_write(12'h408, 64'd50, 8'hFF, r);
        tick(13);
        n_checks++;
        if (seq_busy_o !== 1'b1 || core_clk_en_vec_o[1] !== 1'b0)
            $display("FAIL settle_ignored: busy=%b en1=%b want 1/0", seq_busy_o, core_clk_en_vec_o[1]);
        else n_pass++;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b1) $display("FAIL settle_ungate: busy=%b want 1", seq_busy_o); else n_pass++;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b0 || core_clk_en_vec_o[1] !== 1'b1 || core_pll_fb_div_vec_o[FW +: FW] !== 12'd50)
            $display("FAIL settle_done: busy=%b en1=%b div=%0d want 0/1/50", seq_busy_o, core_clk_en_vec_o[1], core_pll_fb_div_vec_o[FW +: FW]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic [1:0] r; exp_t e;
        logic [11:0] addrs [4];
        exp_t exps [4];
        int k;
        core_pll_locked_i[0] = 1'b0;
        bus_write(12'h400, 64'd77, 8'hFF, r);
        bus_write(12'h400, 64'd99, 8'hFF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL busy_same_wresp: got %b want 10", r); else n_pass++;
        bus_write(12'h800, 64'd5, 8'hFF, r);
        n_checks++;
        if (r !== 2'b10) $display("FAIL busy_ram_wresp: got %b want 10", r); else n_pass++;
        bus_write(12'hE08, 64'h1F, 8'hFF, r);
        bus_write(12'hE28, 64'h1, 8'hFF, r);
        n_checks++;
        if (core_clk_en_vec_o[0] !== 1'b0) $display("FAIL busy_still_gated: en0=%b want 0", core_clk_en_vec_o[0]);
        else n_pass++;
        addrs = '{12'h400, 12'h800, 12'hE20, 12'hE08};
        exps  = '{'{64'd77, 2'b00}, '{64'd40, 2'b00}, '{64'h8000_0000_0000_0000, 2'b00}, '{64'h1F, 2'b00}};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(exps[i]);
            bus_read(addrs[i], d, r);
            e = sb_q.pop_front();
            n_checks++;
            if (d !== e.data || r !== e.resp)
                $display("FAIL busy_read %h: got %h/%b want %h/%b", addrs[i], d, r, e.data, e.resp);
            else n_pass++;
        end
        core_pll_locked_i[0] = 1'b1;
        k = 0;
        while (seq_busy_o && k < 100) begin tick(1); k++; end
        n_checks++;
        if (seq_busy_o !== 1'b0 || core_clk_en_vec_o[0] !== 1'b1 || core_pll_fb_div_vec_o[FW-1:0] !== 12'd77)
            $display("FAIL busy_finish: busy=%b en0=%b div=%0d want 0/1/77", seq_busy_o, core_clk_en_vec_o[0], core_pll_fb_div_vec_o[FW-1:0]);
        else n_pass++;
    endtask

    task automatic test_ram_timeout();
        logic [63:0] d; logic [1:0] r; exp_t e;
        ram_pll_locked_i = 1'b0;
        bus_write(12'h800, 64'd20, 8'hFF, r);
        tick(1028);
        n_checks++;
        if (seq_busy_o !== 1'b1 || ram_clk_en_o !== 1'b0)
            $display("FAIL tmo_before: busy=%b ram_en=%b want 1/0", seq_busy_o, ram_clk_en_o);
        else n_pass++;
        tick(1);
        n_checks++;
        if (seq_busy_o !== 1'b0 || ram_clk_en_o !== 1'b0 || ram_pll_fb_div_o !== 12'd20)
            $display("FAIL tmo_fired: busy=%b ram_en=%b div=%0d want 0/0/20", seq_busy_o, ram_clk_en_o, ram_pll_fb_div_o);
        else n_pass++;
        sb_q.push_back('{64'h10, 2'b00});
        bus_read(12'hE28, d, r);
        e = sb_q.pop_front();
        n_checks++;
        if (d !== e.data || r !== e.resp) $display("FAIL tmo_flag: got %h/%b want %h/%b", d, r, e.data, e.resp);
        else n_pass++;
        bus_write(12'hE28, 64'h10, 8'hFF, r);
        n_checks++;
        if (r !== 2'b00 || ram_clk_en_o !== 1'b1 || ram_pll_fb_div_o !== 12'd20)
            $display("FAIL tmo_clear: resp=%b ram_en=%b div=%0d want 00/1/20", r, ram_clk_en_o, ram_pll_fb_div_o);
        else n_pass++;
        sb_q.push_back('{64'h0, 2'b00});
        bus_read(12'hE28, d, r);
        e = sb_q.pop_front();
        n_checks++;
        if (d !== e.data || r !== e.resp) $display("FAIL tmo_flag_cleared: got %h/%b want %h/%b", d, r, e.data, e.resp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic [1:0] r; exp_t e;
        core_pll_locked_i[3] = 1'b0;
        bus_write(12'h418, 64'd33, 8'hFF, r);
        tick(6);
        #2 arst_ni = 1'b0;
        #1;
        n_checks++;
        if (seq_busy_o !== 1'b0 || core_pll_fb_div_vec_o[3*FW +: FW] !== 12'd40 || core_clk_en_vec_o !== 4'h0)
            $display("FAIL rst_mid: busy=%b div3=%0d clk_en=%h want 0/40/0", seq_busy_o, core_pll_fb_div_vec_o[3*FW +: FW], core_clk_en_vec_o);
        else n_pass++;
        @(negedge clk_i) arst_ni = 1'b1;
        bus_write(12'hE08, 64'h1F, 8'hFF, r);
        n_checks++;
        if (core_clk_en_vec_o !== 4'hF || ram_clk_en_o !== 1'b1)
            $display("FAIL rst_mid_ungated: clk_en=%h ram_en=%b want f/1", core_clk_en_vec_o, ram_clk_en_o);
        else n_pass++;
        sb_q.push_back('{64'd40, 2'b00});
        bus_read(12'h418, d, r);
        e = sb_q.pop_front();
        n_checks++;
        if (d !== e.data || r !== e.resp) $display("FAIL rst_mid_target: got %h/%b want %h/%b", d, r, e.data, e.resp);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ro_write();
        test_readback();
        test_retune_lock10();
        test_lock_settle();
        test_back_to_back();
        test_ram_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
